// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL timer block: prescaler defaults and status byte layout.
package jtopl_pkg;

  localparam int SAMPLES_PER_TICK_A = 4;
  localparam int SAMPLES_PER_TICK_B = 16;

  localparam logic [2:0] STATUS_IRQ_BIT = 3'd7;
  localparam logic [2:0] STATUS_FA_BIT  = 3'd6;
  localparam logic [2:0] STATUS_FB_BIT  = 3'd5;

endpackage

// File: rtl/jtopl_timer_cnt.sv
// One OPL timer: 8-bit up-counter with load-edge preset, wrap detection and a
// latched overflow flag.
module jtopl_timer_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic [7:0] value_i,
  input  logic       load_i,
  input  logic       flagen_i,
  input  logic       clr_i,
  output logic       flag_o,
  output logic       ovf_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       load_q;
  logic       flag_q, flag_d;
  logic       load_edge;
  logic       ovf_w;

  always_comb begin
    load_edge = load_i && !load_q;
    ovf_w     = 1'b0;
    cnt_d     = cnt_q;
    // A load edge takes priority over a coincident tick: the preset is not counted.
    if (load_edge) begin
      cnt_d = value_i;
    end else if (load_i && tick_i) begin
      if (cnt_q == 8'hFF) begin
        cnt_d = value_i;
        ovf_w = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    // Set beats clear so an overflow landing on a clear is never lost.
    flag_d = flag_q;
    if (ovf_w && flagen_i) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 8'h00;
      load_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      load_q <= load_i;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;
  assign ovf_o  = ovf_w;

endmodule

// File: rtl/jtopl_timers.sv
// OPL timers A/B with sample prescalers, status byte and IRQ line.
// Optional CSM key-on pulse enabled by defining JTOPL_CSM_EN.
module jtopl_timers
  import jtopl_pkg::*;
#(
  parameter int PRE_A = SAMPLES_PER_TICK_A,
  parameter int PRE_B = SAMPLES_PER_TICK_B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cenop,
  input  logic       zero,
  input  logic [7:0] value_A,
  input  logic [7:0] value_B,
  input  logic       load_A,
  input  logic       load_B,
  input  logic       flagen_A,
  input  logic       flagen_B,
  input  logic       clr_flag_A,
  input  logic       clr_flag_B,
  input  logic       csm_en,
  output logic       flag_A,
  output logic       flag_B,
  output logic       overflow_A,
  output logic       irq_n,
  output logic [7:0] status,
  output logic       csm_kon
);

  localparam logic [3:0] PRE_A_LAST = 4'(PRE_A - 1);
  localparam logic [5:0] PRE_B_LAST = 6'(PRE_B - 1);

  logic       smp, tick_A, tick_B;
  logic [3:0] presc_A_q, presc_A_d;
  logic [5:0] presc_B_q, presc_B_d;
  logic       ovf_A;
  logic       ovf_b_unused;
  logic       overflow_A_q;
  logic [7:0] status_w;

  // Prescalers run freely so timer phase is independent of load.
  always_comb begin
    smp       = cenop && zero;
    tick_A    = smp && (presc_A_q == PRE_A_LAST);
    tick_B    = smp && (presc_B_q == PRE_B_LAST);
    presc_A_d = presc_A_q;
    presc_B_d = presc_B_q;
    if (smp) begin
      presc_A_d = tick_A ? 4'd0 : presc_A_q + 4'd1;
      presc_B_d = tick_B ? 6'd0 : presc_B_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_A_q    <= 4'd0;
      presc_B_q    <= 6'd0;
      overflow_A_q <= 1'b0;
    end else begin
      presc_A_q    <= presc_A_d;
      presc_B_q    <= presc_B_d;
      overflow_A_q <= ovf_A;
    end
  end

  jtopl_timer_cnt u_timer_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick_A),
    .value_i  (value_A),
    .load_i   (load_A),
    .flagen_i (flagen_A),
    .clr_i    (clr_flag_A),
    .flag_o   (flag_A),
    .ovf_o    (ovf_A)
  );

  jtopl_timer_cnt u_timer_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick_B),
    .value_i  (value_B),
    .load_i   (load_B),
    .flagen_i (flagen_B),
    .clr_i    (clr_flag_B),
    .flag_o   (flag_B),
    .ovf_o    (ovf_b_unused)
  );

`ifdef JTOPL_CSM_EN
  logic csm_kon_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csm_kon_q <= 1'b0;
    end else begin
      csm_kon_q <= ovf_A && csm_en;
    end
  end

  assign csm_kon = csm_kon_q;
`else
  logic csm_en_unused;
  assign csm_en_unused = csm_en;
  assign csm_kon       = 1'b0;
`endif

  always_comb begin
    status_w                 = 8'h00;
    status_w[STATUS_IRQ_BIT] = flag_A | flag_B;
    status_w[STATUS_FA_BIT]  = flag_A;
    status_w[STATUS_FB_BIT]  = flag_B;
  end

  assign overflow_A = overflow_A_q;
  assign irq_n      = ~(flag_A | flag_B);
  assign status     = status_w;

endmodule

// File: tb/tb_jtopl_timers.sv
// Directed bench for jtopl_timers; expected csm_kon follows JTOPL_CSM_EN.
module tb_jtopl_timers;

  logic       clk = 1'b0;
  logic       rst_n, cenop, zero;
  logic [7:0] value_A, value_B;
  logic       load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B, csm_en;
  logic       flag_A, flag_B, overflow_A, irq_n, csm_kon;
  logic [7:0] status;

  int   tests = 0;
  int   fails = 0;
  int   s;
  logic ov_seen, kon_seen, fl_seen;
  logic kon_exp;

  always #5 clk = ~clk;

  jtopl_timers dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cenop      (cenop),
    .zero       (zero),
    .value_A    (value_A),
    .value_B    (value_B),
    .load_A     (load_A),
    .load_B     (load_B),
    .flagen_A   (flagen_A),
    .flagen_B   (flagen_B),
    .clr_flag_A (clr_flag_A),
    .clr_flag_B (clr_flag_B),
    .csm_en     (csm_en),
    .flag_A     (flag_A),
    .flag_B     (flag_B),
    .overflow_A (overflow_A),
    .irq_n      (irq_n),
    .status     (status),
    .csm_kon    (csm_kon)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (sample %0d)", tag, obs, exp, s);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample: zero high for one clk, then one idle clk.
  task automatic do_sample();
    zero = 1'b1;
    step();
    ov_seen  = overflow_A;
    kon_seen = csm_kon;
    fl_seen  = flag_A;
    s++;
    zero = 1'b0;
    step();
    chk("ovf_width", {7'd0, overflow_A}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; cenop = 1'b1; zero = 1'b0;
    value_A = 8'h00; value_B = 8'h00;
    load_A = 1'b0; load_B = 1'b0; flagen_A = 1'b0; flagen_B = 1'b0;
    clr_flag_A = 1'b0; clr_flag_B = 1'b0; csm_en = 1'b0;
    s = 0;
    step(); step();
    chk("rst_flag_A", {7'd0, flag_A}, 8'd0);
    chk("rst_flag_B", {7'd0, flag_B}, 8'd0);
    chk("rst_ovf", {7'd0, overflow_A}, 8'd0);
    chk("rst_kon", {7'd0, csm_kon}, 8'd0);
    chk("rst_irq_n", {7'd0, irq_n}, 8'd1);
    chk("rst_status", status, 8'h00);
    rst_n = 1'b1;
    step();

    // Timer A from FE: overflow every 2 ticks = 8 samples.
    value_A = 8'hFE; flagen_A = 1'b1; load_A = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      do_sample();
      chk("a_fe_ovf", {7'd0, ov_seen}, {7'd0, (s % 8) == 0});
    end
    chk("a_fe_flag", {7'd0, flag_A}, 8'd1);
    chk("a_fe_irq_n", {7'd0, irq_n}, 8'd0);
    chk("a_fe_status", status, 8'hC0);

    // Flag clear, then FF preset with flagen off: overflow every tick, no flag.
    flagen_A = 1'b0; clr_flag_A = 1'b1;
    step();
    clr_flag_A = 1'b0;
    chk("a_clr_flag", {7'd0, flag_A}, 8'd0);
    chk("a_clr_irq_n", {7'd0, irq_n}, 8'd1);
    value_A = 8'hFF; csm_en = 1'b1; load_A = 1'b0;
    step();
    load_A = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      do_sample();
      chk("a_ff_ovf", {7'd0, ov_seen}, {7'd0, (s % 4) == 0});
`ifdef JTOPL_CSM_EN
      kon_exp = ((s % 4) == 0);
`else
      kon_exp = 1'b0;
`endif
      chk("csm_kon", {7'd0, kon_seen}, {7'd0, kon_exp});
      chk("a_ff_noflag", {7'd0, fl_seen}, 8'd0);
      chk("a_ff_irq_n", {7'd0, irq_n}, 8'd1);
    end
    csm_en = 1'b0;

    // Set and clear on the same clk: set wins.
    flagen_A = 1'b1;
    for (int i = 0; i < 4; i++) do_sample();
    chk("sc_flag_set", {7'd0, fl_seen}, 8'd1);
    clr_flag_A = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_sample();
      if (s == 31) chk("sc_flag_cleared", {7'd0, fl_seen}, 8'd0);
    end
    chk("sc_set_wins", {7'd0, fl_seen}, 8'd1);
    clr_flag_A = 1'b0; flagen_A = 1'b0; load_A = 1'b0;
    step();

    // Timer B from F0: 16 ticks of 16 samples -> flag at sample 288.
    value_B = 8'hF0; flagen_B = 1'b1; load_B = 1'b1;
    step();
    while (s < 288) begin
      do_sample();
      if (s == 287) chk("b_flag_early", {7'd0, flag_B}, 8'd0);
    end
    chk("b_flag", {7'd0, flag_B}, 8'd1);
    chk("b_status", status, 8'hA0);
    chk("b_irq_n", {7'd0, irq_n}, 8'd0);
    clr_flag_B = 1'b1;
    step();
    clr_flag_B = 1'b0; load_B = 1'b0;
    chk("b_clr_flag", {7'd0, flag_B}, 8'd0);
    chk("b_clr_irq_n", {7'd0, irq_n}, 8'd1);
    chk("b_clr_status", status, 8'h00);

    // Pause: drop load_A at FF, 20 samples, re-raise reloads FE.
    value_A = 8'hFE; flagen_A = 1'b1; load_A = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      do_sample();
      chk("p_run_ovf", {7'd0, ov_seen}, 8'd0);
    end
    load_A = 1'b0;
    for (int i = 0; i < 20; i++) begin
      do_sample();
      chk("p_pause_ovf", {7'd0, ov_seen}, 8'd0);
    end
    load_A = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      do_sample();
      chk("p_restart_ovf", {7'd0, ov_seen}, {7'd0, s == 320});
    end
    chk("p_flag", {7'd0, flag_A}, 8'd1);

    // Reset mid-count with load_A held high.
    rst_n = 1'b0;
    step();
    chk("mid_rst_flag_A", {7'd0, flag_A}, 8'd0);
    chk("mid_rst_flag_B", {7'd0, flag_B}, 8'd0);
    chk("mid_rst_ovf", {7'd0, overflow_A}, 8'd0);
    chk("mid_rst_irq_n", {7'd0, irq_n}, 8'd1);
    chk("mid_rst_status", status, 8'h00);
    rst_n = 1'b1;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      do_sample();
      chk("post_rst_ovf", {7'd0, ov_seen}, {7'd0, s == 8});
    end
    chk("post_rst_flag", {7'd0, flag_A}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
